// File: rtl/decode_pipe_pkg.sv
// decode_pipe_pkg
//   Shared definitions for the decode stage: RV32 base opcodes, the ALU
//   operation encodings that decode hands to EX, the immediate-format enum
//   and a helper that assembles the 32-bit sign-extended immediate.
//   No ports; imported by decode_ctrl and decode_pipe.
package decode_pipe_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_NREGS = 32;

  // RV32I major opcodes recognised by the decoder
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU operations follow funct3; ADD is used for address/link arithmetic
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SR  = 3'b101;

  // Branch conditions that compare for (in)equality
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Builds the immediate for the given format, already sign-extended to 32 bits
  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// decode_ctrl
//   Purely combinational control decoder: maps opcode/funct3/funct7 to the
//   bundle control bits, the immediate format and which source registers the
//   instruction actually reads (used by the load-use hazard check).
//   Ports:
//     opcode_i, funct3_i, funct7_5_i  instruction fields (funct7_5_i = instr[30])
//     has_imm_o .. check_eq_o         control bits for the EX bundle
//     imm_fmt_o                       immediate format to assemble
//     rs1_used_o, rs2_used_o          source operands really consumed
module decode_ctrl
  import decode_pipe_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic       has_imm_o,
  output logic [2:0] alu_op_o,
  output logic       alu_alt_o,
  output logic       rf_we_o,
  output logic       mem_we_o,
  output logic       mem2rf_o,
  output logic       branch_o,
  output logic       check_eq_o,
  output imm_fmt_e   imm_fmt_o,
  output logic       rs1_used_o,
  output logic       rs2_used_o
);

  // Unknown opcodes fall through to the defaults: a NOP with no control bits.
  // rs1 counts as used for everything except the U-types and JAL.
  always_comb begin
    has_imm_o  = 1'b0;
    alu_op_o   = ALU_ADD;
    alu_alt_o  = 1'b0;
    rf_we_o    = 1'b0;
    mem_we_o   = 1'b0;
    mem2rf_o   = 1'b0;
    branch_o   = 1'b0;
    check_eq_o = 1'b0;
    imm_fmt_o  = IMM_NONE;
    rs1_used_o = 1'b1;
    rs2_used_o = 1'b0;
    case (opcode_i)
      OPC_LUI, OPC_AUIPC: begin
        has_imm_o  = 1'b1;
        rf_we_o    = 1'b1;
        imm_fmt_o  = IMM_U;
        rs1_used_o = 1'b0;
      end
      OPC_JAL: begin
        has_imm_o  = 1'b1;
        rf_we_o    = 1'b1;
        branch_o   = 1'b1;
        imm_fmt_o  = IMM_J;
        rs1_used_o = 1'b0;
      end
      OPC_JALR: begin
        has_imm_o = 1'b1;
        rf_we_o   = 1'b1;
        branch_o  = 1'b1;
        imm_fmt_o = IMM_I;
      end
      OPC_BRANCH: begin
        alu_op_o   = funct3_i;
        branch_o   = 1'b1;
        check_eq_o = (funct3_i == F3_BEQ) || (funct3_i == F3_BNE);
        imm_fmt_o  = IMM_B;
        rs2_used_o = 1'b1;
      end
      OPC_LOAD: begin
        has_imm_o = 1'b1;
        rf_we_o   = 1'b1;
        mem2rf_o  = 1'b1;
        imm_fmt_o = IMM_I;
      end
      OPC_STORE: begin
        has_imm_o  = 1'b1;
        mem_we_o   = 1'b1;
        imm_fmt_o  = IMM_S;
        rs2_used_o = 1'b1;
      end
      OPC_OPIMM: begin
        has_imm_o = 1'b1;
        rf_we_o   = 1'b1;
        alu_op_o  = funct3_i;
        alu_alt_o = (funct3_i == ALU_SR) && funct7_5_i;
        imm_fmt_o = IMM_I;
      end
      OPC_OP: begin
        rf_we_o    = 1'b1;
        alu_op_o   = funct3_i;
        alu_alt_o  = funct7_5_i;
        rs2_used_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe
//   Single-stage decode with register file, load-use hazard stall, optional
//   write-back bypass and a valid/ready output bundle register.
//   Ports:
//     clk, rst                      clock and async active-high reset
//     in_valid_i/in_ready_o         handshake with fetch
//     instr_i, pc_plus1_i           instruction word and next PC from fetch
//     rf_we_i/rf_waddr_i/rf_wdata_i write-back port into the register file
//     flush_i                       kill bundle and incoming instruction
//     out_valid_o/out_ready_i       handshake with execute
//     has_imm_o .. pc_plus1_o       registered decoded bundle
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int XLEN      = DEFAULT_XLEN,
  parameter int NREGS     = DEFAULT_NREGS,
  parameter int BYPASS_WB = 1,
  localparam int RAW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_plus1_i,
  input  logic            rf_we_i,
  input  logic [RAW-1:0]  rf_waddr_i,
  input  logic [XLEN-1:0] rf_wdata_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            has_imm_o,
  output logic [2:0]      alu_op_o,
  output logic            alu_alt_o,
  output logic            rf_we_o,
  output logic            mem_we_o,
  output logic            mem2rf_o,
  output logic            branch_o,
  output logic            check_eq_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] rf_data0_o,
  output logic [XLEN-1:0] rf_data1_o,
  output logic [RAW-1:0]  rf_waddr_o,
  output logic [XLEN-1:0] pc_plus1_o
);

  typedef struct packed {
    logic            has_imm;
    logic [2:0]      alu_op;
    logic            alu_alt;
    logic            rf_we;
    logic            mem_we;
    logic            mem2rf;
    logic            branch;
    logic            check_eq;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rdata0;
    logic [XLEN-1:0] rdata1;
    logic [RAW-1:0]  waddr;
    logic [XLEN-1:0] pc_plus1;
  } bundle_t;

  logic [XLEN-1:0] regs_q [NREGS];
  bundle_t         bundle_q, bundle_d;
  logic            valid_q, valid_d;

  logic [RAW-1:0]  rs1, rs2, rd;
  logic [XLEN-1:0] rdata0, rdata1;
  logic            bypass0, bypass1;
  logic            hazard, advance, accept;

  logic            dHasImm, dAluAlt, dRfWe, dMemWe, dMem2rf, dBranch, dCheckEq;
  logic [2:0]      dAluOp;
  imm_fmt_e        immFmt;
  logic            rs1Used, rs2Used;

  assign rs1 = RAW'(instr_i[19:15]);
  assign rs2 = RAW'(instr_i[24:20]);
  assign rd  = RAW'(instr_i[11:7]);

  decode_ctrl u_ctrl (
    .opcode_i   (instr_i[6:0]),
    .funct3_i   (instr_i[14:12]),
    .funct7_5_i (instr_i[30]),
    .has_imm_o  (dHasImm),
    .alu_op_o   (dAluOp),
    .alu_alt_o  (dAluAlt),
    .rf_we_o    (dRfWe),
    .mem_we_o   (dMemWe),
    .mem2rf_o   (dMem2rf),
    .branch_o   (dBranch),
    .check_eq_o (dCheckEq),
    .imm_fmt_o  (immFmt),
    .rs1_used_o (rs1Used),
    .rs2_used_o (rs2Used)
  );

  // Register file storage; entry 0 is never written and is masked on read
  always_ff @(posedge clk) begin
    if (rf_we_i && (rf_waddr_i != '0)) begin
      regs_q[rf_waddr_i] <= rf_wdata_i;
    end
  end

  // A write landing this cycle is forwarded so decode never sees stale data
  assign bypass0 = (BYPASS_WB != 0) && rf_we_i && (rf_waddr_i == rs1);
  assign bypass1 = (BYPASS_WB != 0) && rf_we_i && (rf_waddr_i == rs2);
  assign rdata0  = (rs1 == '0) ? '0 : (bypass0 ? rf_wdata_i : regs_q[rs1]);
  assign rdata1  = (rs2 == '0) ? '0 : (bypass1 ? rf_wdata_i : regs_q[rs2]);

  // Load result is not available until after EX/MEM, so a dependent
  // instruction directly behind a load waits one cycle
  assign hazard = valid_q && bundle_q.mem2rf && (bundle_q.waddr != '0) &&
                  ((rs1Used && (rs1 == bundle_q.waddr)) ||
                   (rs2Used && (rs2 == bundle_q.waddr)));

  assign advance    = out_ready_i || !valid_q;
  assign in_ready_o = advance && !hazard && !flush_i;
  assign accept     = in_valid_i && in_ready_o;

  // Next bundle contents assembled from the incoming instruction
  always_comb begin
    bundle_d          = '0;
    bundle_d.has_imm  = dHasImm;
    bundle_d.alu_op   = dAluOp;
    bundle_d.alu_alt  = dAluAlt;
    bundle_d.rf_we    = dRfWe;
    bundle_d.mem_we   = dMemWe;
    bundle_d.mem2rf   = dMem2rf;
    bundle_d.branch   = dBranch;
    bundle_d.check_eq = dCheckEq;
    bundle_d.imm      = XLEN'($signed(gen_imm(instr_i, immFmt)));
    bundle_d.rdata0   = rdata0;
    bundle_d.rdata1   = rdata1;
    bundle_d.waddr    = rd;
    bundle_d.pc_plus1 = pc_plus1_i;
  end

  // Valid drops when the bundle is consumed or flushed without a replacement
  always_comb begin
    valid_d = valid_q;
    if (accept) begin
      valid_d = 1'b1;
    end else if (advance || flush_i) begin
      valid_d = 1'b0;
    end
  end

  // Bundle fields only change on accept; bubbles keep the old field values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        bundle_q <= bundle_d;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign has_imm_o   = bundle_q.has_imm;
  assign alu_op_o    = bundle_q.alu_op;
  assign alu_alt_o   = bundle_q.alu_alt;
  assign rf_we_o     = bundle_q.rf_we;
  assign mem_we_o    = bundle_q.mem_we;
  assign mem2rf_o    = bundle_q.mem2rf;
  assign branch_o    = bundle_q.branch;
  assign check_eq_o  = bundle_q.check_eq;
  assign imm_o       = bundle_q.imm;
  assign rf_data0_o  = bundle_q.rdata0;
  assign rf_data1_o  = bundle_q.rdata1;
  assign rf_waddr_o  = bundle_q.waddr;
  assign pc_plus1_o  = bundle_q.pc_plus1;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe
//   Drives decode_pipe with directed scenarios followed by randomized traffic
//   and compares every output against a behavioural model of the decode stage.
module tb_decode_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_plus1_i;
  logic        rf_we_i;
  logic [4:0]  rf_waddr_i;
  logic [31:0] rf_wdata_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        has_imm_o;
  logic [2:0]  alu_op_o;
  logic        alu_alt_o;
  logic        rf_we_o;
  logic        mem_we_o;
  logic        mem2rf_o;
  logic        branch_o;
  logic        check_eq_o;
  logic [31:0] imm_o;
  logic [31:0] rf_data0_o;
  logic [31:0] rf_data1_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] pc_plus1_o;

  decode_pipe #(.XLEN(32), .NREGS(32), .BYPASS_WB(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .pc_plus1_i  (pc_plus1_i),
    .rf_we_i     (rf_we_i),
    .rf_waddr_i  (rf_waddr_i),
    .rf_wdata_i  (rf_wdata_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .has_imm_o   (has_imm_o),
    .alu_op_o    (alu_op_o),
    .alu_alt_o   (alu_alt_o),
    .rf_we_o     (rf_we_o),
    .mem_we_o    (mem_we_o),
    .mem2rf_o    (mem2rf_o),
    .branch_o    (branch_o),
    .check_eq_o  (check_eq_o),
    .imm_o       (imm_o),
    .rf_data0_o  (rf_data0_o),
    .rf_data1_o  (rf_data1_o),
    .rf_waddr_o  (rf_waddr_o),
    .pc_plus1_o  (pc_plus1_o)
  );

  typedef struct packed {
    logic        hasImm;
    logic [2:0]  aluOp;
    logic        aluAlt;
    logic        rfWe;
    logic        memWe;
    logic        mem2rf;
    logic        branch;
    logic        checkEq;
    logic [31:0] imm;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [4:0]  waddr;
    logic [31:0] pc;
  } bundle_t;

  typedef struct packed {
    bundle_t b;
    logic    rs1Used;
    logic    rs2Used;
  } ref_t;

  int          vecCount;
  int          missCount;
  logic [31:0] rfModel [32];
  logic        mValid;
  bundle_t     mBundle;

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Instruction semantics as the decode stage is meant to present them
  function automatic ref_t decodeRef(input logic [31:0] ins);
    ref_t       r;
    int         sins;
    logic [2:0] f3;
    r         = '0;
    f3        = ins[14:12];
    sins      = $signed(ins);
    r.rs1Used = 1'b1;
    case (ins[6:0])
      7'h37, 7'h17: begin
        r.b.rfWe = 1'b1; r.b.hasImm = 1'b1; r.rs1Used = 1'b0;
        r.b.imm  = ins & 32'hFFFF_F000;
      end
      7'h6F: begin
        r.b.rfWe = 1'b1; r.b.hasImm = 1'b1; r.b.branch = 1'b1; r.rs1Used = 1'b0;
        r.b.imm  = ((sins >>> 31) << 20) | (int'(ins[19:12]) << 12) |
                   (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
      end
      7'h67: begin
        r.b.rfWe = 1'b1; r.b.hasImm = 1'b1; r.b.branch = 1'b1;
        r.b.imm  = sins >>> 20;
      end
      7'h63: begin
        r.b.branch  = 1'b1; r.rs2Used = 1'b1; r.b.aluOp = f3;
        r.b.checkEq = (f3 == 3'd0) || (f3 == 3'd1);
        r.b.imm     = ((sins >>> 31) << 12) | (int'(ins[7]) << 11) |
                      (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
      end
      7'h03: begin
        r.b.rfWe = 1'b1; r.b.hasImm = 1'b1; r.b.mem2rf = 1'b1;
        r.b.imm  = sins >>> 20;
      end
      7'h23: begin
        r.b.memWe = 1'b1; r.b.hasImm = 1'b1; r.rs2Used = 1'b1;
        r.b.imm   = ((sins >>> 25) << 5) | int'(ins[11:7]);
      end
      7'h13: begin
        r.b.rfWe   = 1'b1; r.b.hasImm = 1'b1; r.b.aluOp = f3;
        r.b.aluAlt = (f3 == 3'd5) && ins[30];
        r.b.imm    = sins >>> 20;
      end
      7'h33: begin
        r.b.rfWe   = 1'b1; r.rs2Used = 1'b1; r.b.aluOp = f3;
        r.b.aluAlt = ins[30];
      end
      default: begin
      end
    endcase
    return r;
  endfunction

  // Register read as seen during the cycle, including same-cycle write-back
  function automatic logic [31:0] rfRead(input logic [4:0] a, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && (wa == a)) return wd;
    return rfModel[a];
  endfunction

  function automatic logic [31:0] randInstr();
    logic [6:0]  opcs [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                               7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
    logic [31:0] ins;
    ins        = $urandom;
    ins[6:0]   = opcs[$urandom_range(0, 9)];
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    ins[11:7]  = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  task automatic compareBundle();
    checkOutput("out_valid", 32'(out_valid_o), 32'(mValid));
    checkOutput("has_imm",   32'(has_imm_o),   32'(mBundle.hasImm));
    checkOutput("alu_op",    32'(alu_op_o),    32'(mBundle.aluOp));
    checkOutput("alu_alt",   32'(alu_alt_o),   32'(mBundle.aluAlt));
    checkOutput("rf_we",     32'(rf_we_o),     32'(mBundle.rfWe));
    checkOutput("mem_we",    32'(mem_we_o),    32'(mBundle.memWe));
    checkOutput("mem2rf",    32'(mem2rf_o),    32'(mBundle.mem2rf));
    checkOutput("branch",    32'(branch_o),    32'(mBundle.branch));
    checkOutput("check_eq",  32'(check_eq_o),  32'(mBundle.checkEq));
    checkOutput("imm",       imm_o,            mBundle.imm);
    checkOutput("rf_data0",  rf_data0_o,       mBundle.data0);
    checkOutput("rf_data1",  rf_data1_o,       mBundle.data1);
    checkOutput("rf_waddr",  32'(rf_waddr_o),  32'(mBundle.waddr));
    checkOutput("pc_plus1",  pc_plus1_o,       mBundle.pc);
  endtask

  // One clock cycle: drive inputs, check the handshake, advance the model
  // across the edge and check the registered bundle
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic fl, input logic ordy);
    ref_t d;
    logic hz;
    logic expReady;
    in_valid_i  = v;
    instr_i     = ins;
    pc_plus1_i  = pc;
    rf_we_i     = we;
    rf_waddr_i  = wa;
    rf_wdata_i  = wd;
    flush_i     = fl;
    out_ready_i = ordy;
    #1;
    d  = decodeRef(ins);
    hz = mValid && mBundle.mem2rf && (mBundle.waddr != 5'd0) &&
         ((d.rs1Used && (ins[19:15] == mBundle.waddr)) ||
          (d.rs2Used && (ins[24:20] == mBundle.waddr)));
    expReady = (ordy || !mValid) && !hz && !fl;
    checkOutput("in_ready", 32'(in_ready_o), 32'(expReady));
    d.b.data0 = rfRead(ins[19:15], we, wa, wd);
    d.b.data1 = rfRead(ins[24:20], we, wa, wd);
    d.b.waddr = ins[11:7];
    d.b.pc    = pc;
    @(posedge clk);
    if (v && expReady) begin
      mValid  = 1'b1;
      mBundle = d.b;
    end else if (fl || ordy) begin
      mValid = 1'b0;
    end
    if (we && (wa != 5'd0)) rfModel[wa] = wd;
    #1;
    compareBundle();
  endtask

  // Asynchronous reset pulse between clock edges
  task automatic pulseReset();
    rst = 1'b1;
    #1;
    mValid  = 1'b0;
    mBundle = '0;
    compareBundle();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vecCount    = 0;
    missCount   = 0;
    mValid      = 1'b0;
    mBundle     = '0;
    rfModel[0]  = 32'd0;
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    instr_i     = 32'd0;
    pc_plus1_i  = 32'd0;
    rf_we_i     = 1'b0;
    rf_waddr_i  = 5'd0;
    rf_wdata_i  = 32'd0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    compareBundle();
    rst = 1'b0;

    for (int r = 1; r < 32; r++) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'(r), $urandom, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 32'h1234_5678, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'h0050_0093, 32'h0000_0104, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    checkOutput("addi_valid", 32'(out_valid_o), 32'd1);
    checkOutput("addi_imm",   imm_o,            32'd5);
    checkOutput("addi_himm",  32'(has_imm_o),   32'd1);
    checkOutput("addi_rd",    32'(rf_waddr_o),  32'd1);

    applyStimulus(1'b1, 32'h0000_A103, 32'h0000_0108, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0021_01B3, 32'h0000_010C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    checkOutput("loaduse_bubble", 32'(out_valid_o), 32'd0);
    applyStimulus(1'b1, 32'h0021_01B3, 32'h0000_010C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    checkOutput("loaduse_add_rd", 32'(rf_waddr_o), 32'd3);

    applyStimulus(1'b1, 32'h0002_8333, 32'h0000_0110, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b1);
    checkOutput("bypass_data0", rf_data0_o, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 32'h0050_0093, 32'h0000_0200, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h0031_6233, 32'h0000_0204, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    end
    checkOutput("stall_pc", pc_plus1_o, 32'h0000_0200);
    applyStimulus(1'b1, 32'h0031_6233, 32'h0000_0204, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    checkOutput("release_pc", pc_plus1_o, 32'h0000_0204);

    applyStimulus(1'b1, 32'h0050_0093, 32'h0000_0300, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    checkOutput("flush_valid", 32'(out_valid_o), 32'd0);

    applyStimulus(1'b1, 32'hFFF0_0093, 32'h0000_0400, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0050_0093, 32'h0000_0404, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    pulseReset();
    checkOutput("rst_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_imm",   imm_o,            32'd0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) pulseReset();
      applyStimulus(($urandom_range(0, 9) < 7), randInstr(), $urandom,
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
